// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the ALU/multiplier time-sharing controller:
// operand width, ALU opcode encodings and the sequencer state enum.
package alu_mul_sequencer_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STEP = 2'b01,
    CAPT = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shares the registered ALU between the EX stage and a 32-iteration shift-add
// unsigned multiplier; the ALU is only borrowed for the add steps.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = alu_mul_sequencer_pkg::WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  input  logic [1:0]       ex_op,
  input  logic             ex_binv,
  input  logic             mul_start,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_binv,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             carry;
  logic             lastIter;

  assign lastIter = (count_q == CntW'(WIDTH - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    count_d = count_q;
    // The ALU has no carry-out, so rebuild it from the operand and sum MSBs.
    carry   = (hi_q[WIDTH-1] & mcand_q[WIDTH-1]) |
              ((hi_q[WIDTH-1] | mcand_q[WIDTH-1]) & ~alu_result[WIDTH-1]);
    case (state_q)
      IDLE: begin
        if (mul_start) begin
          hi_d    = '0;
          lo_d    = mul_b;
          mcand_d = mul_a;
          count_d = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        if (lo_q[0]) begin
          state_d = CAPT;
        end else begin
          hi_d    = {1'b0, hi_q[WIDTH-1:1]};
          lo_d    = {hi_q[0], lo_q[WIDTH-1:1]};
          count_d = count_q + CntW'(1);
          state_d = lastIter ? DONE : STEP;
        end
      end
      CAPT: begin
        hi_d    = {carry, alu_result[WIDTH-1:1]};
        lo_d    = {alu_result[0], lo_q[WIDTH-1:1]};
        count_d = count_q + CntW'(1);
        state_d = lastIter ? DONE : STEP;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mul_busy = (state_q == STEP) || (state_q == CAPT);
  assign mul_done = (state_q == DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Operand mux: the multiplier owns the ALU only while busy.
  always_comb begin
    alu_a    = ex_a;
    alu_b    = ex_b;
    alu_op   = ex_op;
    alu_binv = ex_binv;
    if (mul_busy) begin
      alu_a    = hi_q;
      alu_b    = mcand_q;
      alu_op   = OP_ADD;
      alu_binv = 1'b0;
    end
  end

endmodule
